sata_rw_sequencer: RTL and testbench
====================================

SATA_RW_SEQUENCER -- requirements
Module: sata_rw_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: cycles allowed in ISSUE and in WAIT_DONE before abort.
REQ-002 Parameter MAX_RETRY, default 2: retries per command when SATA_SEQ_RETRY_EN is defined.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 linkup, sata_ready, sata_busy  in  1 each  stack status.
REQ-006 d2h_status, d2h_error  in  8 each  last D2H register FIS fields.
REQ-007 wr_req  in  1; wr_sector_address  in  48; wr_sector_count  in  16  write requester.
REQ-008 rd_req  in  1; rd_sector_address  in  48; rd_sector_count  in  16  read requester.
REQ-009 wr_ack, wr_done, wr_err  out  1 each  one-cycle pulses to the write requester.
REQ-010 rd_ack, rd_done, rd_err  out  1 each  one-cycle pulses to the read requester.
REQ-011 write_data_en, read_data_en  out  1 each  command strobes to the stack.
REQ-012 sector_address  out  48; sector_count  out  16  latched command operands.
REQ-013 command_layer_reset  out  1  command-layer reset to the stack.
REQ-014 seq_busy  out  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, ISSUE, WAIT_DONE, CHECK, RESET_CL, RECOVER.
REQ-016 IDLE: a grant occurs only when linkup=1, sata_ready=1, sata_busy=0, and wr_req or rd_req=1.
REQ-017 Arbitration is round-robin: with both requests high, the requester not granted last wins; a single request is granted directly; last-grant resets to read, so write wins the first tie.
REQ-018 On grant: latch address and count into sector_address/sector_count, pulse the owner's ack in the same cycle, and go to ISSUE next cycle.
REQ-019 ISSUE: hold the owner's enable (write_data_en or read_data_en) high until sata_busy=1 is sampled; then deassert it on the next cycle and go to WAIT_DONE.
REQ-020 write_data_en and read_data_en are never high together.
REQ-021 WAIT_DONE: on sata_busy=0, go to CHECK.
REQ-022 CHECK, one cycle: error if d2h_status[0]=1 (ERR), d2h_status[5]=1 (DF), or d2h_error!=0.
REQ-023 CHECK with no error: pulse the owner's done and go to IDLE.
REQ-024 CHECK with error: go to RESET_CL.
REQ-025 A 32-bit timeout counter clears on entry to ISSUE and to WAIT_DONE.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1, deassert enables and go to RESET_CL (error path).
REQ-027 RESET_CL: command_layer_reset=1 for exactly 4 cycles, then RECOVER.
REQ-028 RECOVER: wait for sata_ready=1 and sata_busy=0, then apply the retry/error rule in REQ-034/035.
REQ-029 linkup=0 in any non-IDLE state: next cycle go to IDLE, deassert enables, pulse the owner's err; no retry.
REQ-030 sector_count=0 passes through unchanged (ATA 65536-sector semantics); it is not an error.
REQ-031 Requests are level-sensitive; a request dropped before grant is ignored; operands sampled after ack are don't-care.
REQ-032 Per cycle, at most one ack, one done and one err pulse is asserted.

Reset
REQ-033 rst=0 at a rising edge: state=IDLE, all outputs 0, sector_address=0, sector_count=0, counters=0, last-grant=read; this holds even mid-operation, with no pulses emitted.

Configuration
REQ-034 With SATA_SEQ_RETRY_EN defined, RECOVER re-enters ISSUE with the latched operands while retry_count<MAX_RETRY, incrementing retry_count; otherwise it pulses err and goes to IDLE. retry_count clears on grant.
REQ-035 With SATA_SEQ_RETRY_EN undefined, RECOVER always pulses err and goes to IDLE; no retry counter is built.

Verification
REQ-036 wr_req with address 0x000000001000 and count 8; busy is asserted 3 cycles after the enable and held 20 cycles; status 0x50 -> wr_ack at grant, write_data_en high 3 cycles, sector_address=0x1000, wr_done once, no err.
REQ-037 wr_req and rd_req held high across 3 commands, all succeeding -> grant order write, read, write; each ack is preceded by the prior done.
REQ-038 d2h_status=0x51 at CHECK, macro defined, MAX_RETRY=2 -> 3 ISSUE entries, 3 command_layer_reset bursts of 4 cycles each, then a single rd_err.
REQ-039 sata_busy never rises, TIMEOUT_CYCLES=16 -> enable high 16 cycles, then command_layer_reset, then err (macro undefined).
REQ-040 linkup dropped in WAIT_DONE -> IDLE next cycle with an err pulse; rst=0 in ISSUE -> all outputs 0 next cycle, with no done or err pulse.

Source files
------------

// File: rtl/sata_rw_sequencer.sv
// sata_rw_sequencer
// Arbitrates between a write requester and a read requester and sequences one
// ATA command at a time into the SATA stack. It waits for the stack to accept
// and finish the command, checks the D2H status, and on failure pulses the
// command-layer reset and recovers.
//
// Optional feature macro: SATA_SEQ_RETRY_EN
//   defined   : a failed command is re-issued up to MAX_RETRY times with the
//               latched operands before err is reported.
//   undefined : a failed command reports err right after recovery and no
//               retry counter is built.
//
// All outputs are forced low while rst is low, so no ack/done/err pulse can
// leak out of a reset cycle.

module sata_rw_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        linkup,
    input  logic        sata_ready,
    input  logic        sata_busy,
    input  logic [7:0]  d2h_status,
    input  logic [7:0]  d2h_error,

    input  logic        wr_req,
    input  logic [47:0] wr_sector_address,
    input  logic [15:0] wr_sector_count,
    input  logic        rd_req,
    input  logic [47:0] rd_sector_address,
    input  logic [15:0] rd_sector_count,

    output logic        wr_ack,
    output logic        wr_done,
    output logic        wr_err,
    output logic        rd_ack,
    output logic        rd_done,
    output logic        rd_err,

    output logic        write_data_en,
    output logic        read_data_en,
    output logic [47:0] sector_address,
    output logic [15:0] sector_count,
    output logic        command_layer_reset,
    output logic        seq_busy
);

    // state      | meaning
    // -----------+-------------------------------------------------------------
    // IDLE       | no command; grant when link is up, stack ready and not busy
    // ISSUE      | owner's data enable high until the stack reports busy
    // WAIT_DONE  | stack busy with the command; wait for busy to fall
    // CHECK      | one cycle: inspect D2H status/error, done or fail
    // RESET_CL   | command_layer_reset high for four cycles
    // RECOVER    | wait for stack ready and idle, then retry or report err
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CHECK     = 3'd3,
        ST_RESET_CL  = 3'd4,
        ST_RECOVER   = 3'd5
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_rd_q, owner_rd_d;
    logic        last_rd_q, last_rd_d;
    logic [47:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [1:0]  rcl_q, rcl_d;

    logic        grant_ok;
    logic        grant_wr;
    logic        grant_rd;
    logic        d2h_fail;
    logic        retry_ok;

    logic        ack;
    logic        done;
    logic        err;
    logic        data_en;
    logic        cl_rst;

`ifdef SATA_SEQ_RETRY_EN
    logic [31:0] retry_q, retry_d;

    assign retry_ok = (retry_q < MAX_RETRY);
`else
    // MAX_RETRY only matters when the retry feature is built.
    logic        unused_max_retry;

    assign unused_max_retry = (MAX_RETRY != 0);
    assign retry_ok         = 1'b0;
`endif

    // Only ERR (bit 0) and DF (bit 5) of the status byte abort a command.
    logic        unused_status_bits;

    assign unused_status_bits = ^{d2h_status[7:6], d2h_status[4:1]};

    // Round-robin grant: on a tie the requester that did not win last time goes.
    assign grant_ok = linkup && sata_ready && !sata_busy;
    assign grant_wr = grant_ok && wr_req && (!rd_req || last_rd_q);
    assign grant_rd = grant_ok && rd_req && (!wr_req || !last_rd_q);
    assign d2h_fail = d2h_status[0] || d2h_status[5] || (d2h_error != 8'h00);

    // Next-state, counters and owner-agnostic output strobes.
    always_comb begin
        state_d    = state_q;
        owner_rd_d = owner_rd_q;
        last_rd_d  = last_rd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        rcl_d      = rcl_q;
`ifdef SATA_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif
        ack        = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        data_en    = 1'b0;
        cl_rst     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_wr || grant_rd) begin
                    owner_rd_d = grant_rd;
                    last_rd_d  = grant_rd;
                    addr_d     = grant_rd ? rd_sector_address : wr_sector_address;
                    cnt_d      = grant_rd ? rd_sector_count : wr_sector_count;
                    tmo_d      = '0;
`ifdef SATA_SEQ_RETRY_EN
                    retry_d    = '0;
`endif
                    ack        = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!linkup) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    data_en = 1'b1;
                    if (sata_busy) begin
                        tmo_d   = '0;
                        state_d = ST_WAIT_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        rcl_d   = '0;
                        state_d = ST_RESET_CL;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!linkup) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (!sata_busy) begin
                    state_d = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    rcl_d   = '0;
                    state_d = ST_RESET_CL;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end

            ST_CHECK: begin
                if (!linkup) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (d2h_fail) begin
                    rcl_d   = '0;
                    state_d = ST_RESET_CL;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_RESET_CL: begin
                if (!linkup) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cl_rst = 1'b1;
                    if (rcl_q == 2'd3) begin
                        state_d = ST_RECOVER;
                    end else begin
                        rcl_d = rcl_q + 2'd1;
                    end
                end
            end

            ST_RECOVER: begin
                if (!linkup) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (sata_ready && !sata_busy) begin
                    if (retry_ok) begin
`ifdef SATA_SEQ_RETRY_EN
                        retry_d = retry_q + 32'd1;
`endif
                        tmo_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Steer strobes to the owning requester; owner_rd_d already reflects a
    // grant made this cycle. Everything is held low while reset is asserted.
    always_comb begin
        wr_ack              = 1'b0;
        rd_ack              = 1'b0;
        wr_done             = 1'b0;
        rd_done             = 1'b0;
        wr_err              = 1'b0;
        rd_err              = 1'b0;
        write_data_en       = 1'b0;
        read_data_en        = 1'b0;
        command_layer_reset = 1'b0;
        seq_busy            = 1'b0;
        if (rst) begin
            wr_ack              = ack && !owner_rd_d;
            rd_ack              = ack && owner_rd_d;
            wr_done             = done && !owner_rd_d;
            rd_done             = done && owner_rd_d;
            wr_err              = err && !owner_rd_d;
            rd_err              = err && owner_rd_d;
            write_data_en       = data_en && !owner_rd_d;
            read_data_en        = data_en && owner_rd_d;
            command_layer_reset = cl_rst;
            seq_busy            = (state_q != ST_IDLE);
        end
    end

    assign sector_address = addr_q;
    assign sector_count   = cnt_q;

    // State, operand and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_rd_q <= 1'b0;
            last_rd_q  <= 1'b1;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            rcl_q      <= '0;
`ifdef SATA_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_rd_q <= owner_rd_d;
            last_rd_q  <= last_rd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            rcl_q      <= rcl_d;
`ifdef SATA_SEQ_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_sata_rw_sequencer.sv
// Testbench for sata_rw_sequencer. A stack model answers the data enables with
// configurable busy timing and D2H status; a requester-level reference model
// predicts the grant order and the ack/done/err event list of every command,
// which a negedge monitor matches against the DUT pulses.
// Honours SATA_SEQ_RETRY_EN the same way the design does.

module tb_sata_rw_sequencer;

    localparam int unsigned TMO  = 16;
    localparam int unsigned MAXR = 2;
`ifdef SATA_SEQ_RETRY_EN
    localparam int RETRIES = MAXR;
`else
    localparam int RETRIES = 0;
`endif

    localparam int O_OK    = 0;
    localparam int O_STAT  = 1;
    localparam int O_CODE  = 2;
    localparam int O_TISS  = 3;
    localparam int O_TWAIT = 4;
    localparam int O_LINK  = 5;

    localparam int K_ACK  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic        clk;
    logic        rst;
    logic        linkup, sata_ready, sata_busy;
    logic [7:0]  d2h_status, d2h_error;
    logic        wr_req, rd_req;
    logic [47:0] wr_sector_address, rd_sector_address;
    logic [15:0] wr_sector_count, rd_sector_count;
    logic        wr_ack, wr_done, wr_err, rd_ack, rd_done, rd_err;
    logic        write_data_en, read_data_en;
    logic [47:0] sector_address;
    logic [15:0] sector_count;
    logic        command_layer_reset, seq_busy;

    sata_rw_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst),
        .linkup(linkup), .sata_ready(sata_ready), .sata_busy(sata_busy),
        .d2h_status(d2h_status), .d2h_error(d2h_error),
        .wr_req(wr_req), .wr_sector_address(wr_sector_address), .wr_sector_count(wr_sector_count),
        .rd_req(rd_req), .rd_sector_address(rd_sector_address), .rd_sector_count(rd_sector_count),
        .wr_ack(wr_ack), .wr_done(wr_done), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_done(rd_done), .rd_err(rd_err),
        .write_data_en(write_data_en), .read_data_en(read_data_en),
        .sector_address(sector_address), .sector_count(sector_count),
        .command_layer_reset(command_layer_reset), .seq_busy(seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        bit          rd;
        logic [47:0] addr;
        logic [15:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  last_was_wr = 1'b0;
    bit  mon_en = 1'b0;

    int          stk_dly = 2;
    int          stk_hold = 4;
    logic [7:0]  stk_status = 8'h50;
    logic [7:0]  stk_error = 8'h00;

    int  en_runs[$];
    int  cl_runs[$];
    int  cur_en = 0;
    int  cur_cl = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Stack model: raise busy once an enable has been seen for stk_dly cycles
    // (never if stk_dly is 0), hold it stk_hold cycles, then present status.
    initial begin
        int en_seen;
        en_seen    = 0;
        sata_busy  = 1'b0;
        d2h_status = 8'h50;
        d2h_error  = 8'h00;
        forever begin
            drive_edge();
            if ((write_data_en || read_data_en) && !sata_busy) begin
                en_seen++;
                if (stk_dly != 0 && en_seen == stk_dly) begin
                    sata_busy = 1'b1;
                    en_seen   = 0;
                    repeat (stk_hold) drive_edge();
                    d2h_status = stk_status;
                    d2h_error  = stk_error;
                    sata_busy  = 1'b0;
                end
            end else begin
                en_seen = 0;
            end
        end
    end

    // Monitor: invariants, enable/reset run lengths, scoreboard matching.
    bit   pend_ack = 1'b0;
    ev_t  pend_ev;
    always @(negedge clk) begin
        int  npulse;
        ev_t e;
        int  gkind;
        bit  grd;
        if (mon_en) begin
            if (write_data_en && read_data_en) begin
                tests++; fails++;
                $display("FAIL both enables: got 1, expected 0 (t=%0t)", $time);
            end
            npulse = $countones({wr_ack, wr_done, wr_err, rd_ack, rd_done, rd_err});
            if (npulse > 1) begin
                tests++; fails++;
                $display("FAIL pulse count: got %0d, expected <=1 (t=%0t)", npulse, $time);
            end
            if (write_data_en || read_data_en) cur_en++;
            else if (cur_en > 0) begin en_runs.push_back(cur_en); cur_en = 0; end
            if (command_layer_reset) cur_cl++;
            else if (cur_cl > 0) begin cl_runs.push_back(cur_cl); cur_cl = 0; end
            if (pend_ack) begin
                chk("latched sector_address", sector_address, pend_ev.addr);
                chk("latched sector_count", sector_count, pend_ev.cnt);
                pend_ack = 1'b0;
            end
            if (npulse == 1) begin
                gkind = (wr_ack || rd_ack) ? K_ACK : ((wr_done || rd_done) ? K_DONE : K_ERR);
                grd   = rd_ack || rd_done || rd_err;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected pulse: got kind %0d rd %0d, expected none (t=%0t)", gkind, grd, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event kind", gkind, e.kind);
                    chk("event owner", grd, e.rd);
                    if (gkind == K_ACK) begin
                        pend_ack = 1'b1;
                        pend_ev  = e;
                    end
                end
            end
        end
    end

    function automatic ev_t mk(input int kind, input bit rd, input logic [47:0] a, input logic [15:0] c);
        ev_t e;
        e.kind = kind; e.rd = rd; e.addr = a; e.cnt = c;
        return e;
    endfunction

    // One command from request to idle; pat 0=write, 1=read, 2=both.
    task automatic run_cmd(input int pat, input int oc,
                           input logic [47:0] wa, input logic [15:0] wc,
                           input logic [47:0] ra, input logic [15:0] rc,
                           input int dly, input int hold,
                           input logic [7:0] st, input logic [7:0] er, input int gap);
        bit rd;
        bit got;
        int issues, bursts, exp_en;
        if (pat == 0) rd = 1'b0;
        else if (pat == 1) rd = 1'b1;
        else rd = last_was_wr;
        last_was_wr = !rd;
        exp_q.push_back(mk(K_ACK, rd, rd ? ra : wa, rd ? rc : wc));
        exp_q.push_back(mk((oc == O_OK) ? K_DONE : K_ERR, rd, 48'h0, 16'h0));
        issues = (oc == O_OK || oc == O_LINK) ? 1 : 1 + RETRIES;
        bursts = (oc == O_OK || oc == O_LINK) ? 0 : 1 + RETRIES;
        exp_en = (oc == O_TISS) ? TMO : dly;
        stk_dly = dly; stk_hold = hold; stk_status = st; stk_error = er;
        en_runs.delete(); cl_runs.delete();

        if (gap > 0) sata_ready = 1'b0;
        wr_req = (pat != 1); rd_req = (pat != 0);
        wr_sector_address = wa; wr_sector_count = wc;
        rd_sector_address = ra; rd_sector_count = rc;
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            chk("no grant while not ready", wr_ack | rd_ack, 1'b0);
            drive_edge();
        end
        sata_ready = 1'b1;

        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (wr_ack || rd_ack) got = 1'b1;
        end
        chk("ack seen", got, 1'b1);
        drive_edge();
        wr_req = 1'b0; rd_req = 1'b0;
        wr_sector_address = {16'($urandom), 32'($urandom)};
        rd_sector_address = {16'($urandom), 32'($urandom)};
        wr_sector_count = 16'($urandom); rd_sector_count = 16'($urandom);

        if (oc == O_LINK) begin
            for (int k = 0; k < 20 && !sata_busy; k++) drive_edge();
            drive_edge(); drive_edge();
            linkup = 1'b0;
            drive_edge();
            chk("idle after link loss", seq_busy, 1'b0);
            linkup = 1'b1;
        end

        for (int k = 0; k < 800 && seq_busy; k++) drive_edge();
        chk("sequence finished", seq_busy, 1'b0);
        for (int k = 0; k < 100 && sata_busy; k++) drive_edge();
        drive_edge(); drive_edge();
        chk("issue entries", en_runs.size(), issues);
        foreach (en_runs[i]) chk("enable length", en_runs[i], exp_en);
        chk("reset bursts", cl_runs.size(), bursts);
        foreach (cl_runs[i]) chk("reset burst length", cl_runs[i], 4);
        chk("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        int acks;
        int pat, r, oc, dly, hold;
        logic [7:0]  st, er;
        logic [47:0] wa, ra;
        logic [15:0] wc, rc;

        rst = 1'b0; linkup = 1'b1; sata_ready = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_sector_address = 48'h0; wr_sector_count = 16'h0;
        rd_sector_address = 48'h0; rd_sector_count = 16'h0;
        repeat (3) drive_edge();
        mon_en = 1'b1;
        chk("reset seq_busy", seq_busy, 1'b0);
        chk("reset sector_address", sector_address, 48'h0);
        chk("reset sector_count", sector_count, 16'h0);
        chk("reset enables", {write_data_en, read_data_en, command_layer_reset}, 3'b000);
        rst = 1'b1;
        drive_edge();

        // Both requesters held across three good commands: write, read, write.
        wa = 48'h0000_1234_5678; wc = 16'd16;
        ra = 48'h0000_0000_9000; rc = 16'd4;
        last_was_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit rd;
            rd = last_was_wr;
            last_was_wr = !rd;
            exp_q.push_back(mk(K_ACK, rd, rd ? ra : wa, rd ? rc : wc));
            exp_q.push_back(mk(K_DONE, rd, 48'h0, 16'h0));
        end
        stk_dly = 2; stk_hold = 5; stk_status = 8'h50; stk_error = 8'h00;
        wr_sector_address = wa; wr_sector_count = wc;
        rd_sector_address = ra; rd_sector_count = rc;
        wr_req = 1'b1; rd_req = 1'b1;
        acks = 0;
        for (int k = 0; k < 300 && acks < 3; k++) begin
            @(negedge clk);
            if (wr_ack || rd_ack) acks++;
        end
        chk("round-robin acks", acks, 3);
        drive_edge();
        wr_req = 1'b0; rd_req = 1'b0;
        for (int k = 0; k < 300 && seq_busy; k++) drive_edge();
        drive_edge(); drive_edge();
        chk("round-robin drained", exp_q.size(), 0);

        // Nominal write; busy is held 12 cycles so it completes inside the 16-cycle watchdog.
        run_cmd(0, O_OK, 48'h0000_0000_1000, 16'd8, 48'h0, 16'd1, 3, 12, 8'h50, 8'h00, 0);
        // Read aborted by ERR status bit.
        run_cmd(1, O_STAT, 48'h0, 16'd1, 48'h0000_00AB_C000, 16'd32, 2, 4, 8'h51, 8'h00, 0);
        // Stack never goes busy: ISSUE watchdog.
        run_cmd(0, O_TISS, 48'h0000_0000_2000, 16'd0, 48'h0, 16'd1, 0, 1, 8'h50, 8'h00, 0);
        // Link lost while the stack is busy.
        run_cmd(2, O_LINK, 48'h0000_0000_3000, 16'd2, 48'h0000_0000_4000, 16'd3, 2, 40, 8'h50, 8'h00, 2);

        // Reset taken while a command sits in ISSUE: nothing further is reported.
        last_was_wr = 1'b1;
        wa = 48'h0000_0000_5000;
        exp_q.push_back(mk(K_ACK, 1'b0, wa, 16'd7));
        stk_dly = 0;
        wr_sector_address = wa; wr_sector_count = 16'd7;
        wr_req = 1'b1;
        acks = 0;
        for (int k = 0; k < 40 && acks == 0; k++) begin
            @(negedge clk);
            if (wr_ack) acks = 1;
        end
        chk("ack before reset", acks, 1);
        drive_edge();
        wr_req = 1'b0;
        drive_edge(); drive_edge();
        chk("enable held in issue", write_data_en, 1'b1);
        rst = 1'b0;
        drive_edge();
        chk("post-reset outputs", {write_data_en, read_data_en, command_layer_reset, seq_busy,
                                   wr_ack, wr_done, wr_err, rd_ack, rd_done, rd_err}, 10'h0);
        chk("post-reset sector_address", sector_address, 48'h0);
        chk("post-reset sector_count", sector_count, 16'h0);
        drive_edge();
        rst = 1'b1;
        last_was_wr = 1'b0;
        repeat (4) drive_edge();
        chk("reset drained", exp_q.size(), 0);

        // Randomised commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(0, 2);
            r   = $urandom_range(0, 19);
            oc  = (r < 9) ? O_OK : (r < 11) ? O_STAT : (r < 13) ? O_CODE :
                  (r < 15) ? O_TISS : (r < 17) ? O_TWAIT : O_LINK;
            st  = (oc == O_STAT) ? (($urandom_range(0, 1) == 0) ? 8'h51 : 8'h70)
                                 : (8'($urandom) & 8'hDE);
            er  = (oc == O_CODE) ? 8'($urandom_range(1, 255)) : 8'h00;
            dly = (oc == O_TISS) ? 0 : $urandom_range(1, 4);
            hold = (oc == O_TWAIT || oc == O_LINK) ? 40 : $urandom_range(1, 10);
            wa = {16'($urandom), 32'($urandom)};
            ra = {16'($urandom), 32'($urandom)};
            wc = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            rc = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            run_cmd(pat, oc, wa, wc, ra, rc, dly, hold, st, er,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
